// File: rtl/panel_pkg.sv
// Shared definitions for the LED panel scan path: scan FSM states and
// default panel geometry, also reused by the message shifter.
package panel_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_BLANK = 2'd2
   } scan_state_t;

   localparam int ROWS_DEF            = 7;
   localparam int BLANK_CYCLES_DEF    = 2;
   localparam int FRAMES_PER_STEP_DEF = 50;

endpackage

// File: rtl/panel_scan_scheduler_tick_prescaler.sv
// Loadable 0..div counter: holds its own copy of the reload value and flags
// the terminal count so the scan FSM knows when a row's drive time is over.
module tick_prescaler #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         clr_i,
   input  logic         run_i,
   output logic         tc_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] div_q;

   // Load also zeroes the count so a new frame starts its first row cleanly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         div_q   <= '0;
      end else if (load_i) begin
         count_q <= '0;
         div_q   <= load_val_i;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (run_i) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign tc_o = (count_q == div_q);

endmodule

// File: rtl/panel_scan_scheduler.sv
// Row-scan scheduler for the LED matrix: sequences row drive and blanking,
// marks frame starts and issues scroll-step strobes, all as clock enables.
module panel_scan_scheduler
   import panel_pkg::*;
#(
   parameter int DIV_WIDTH       = 16,
   parameter int ROWS            = ROWS_DEF,
   parameter int BLANK_CYCLES    = BLANK_CYCLES_DEF,
   parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEF,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic [DIV_WIDTH-1:0] DIV,
   output logic [ROWS-1:0]      ROW_SEL,
   output logic [RW-1:0]        ROW_IDX,
   output logic                 BLANK,
   output logic                 FRAME_START,
   output logic                 SCROLL_STEP,
   output scan_state_t          STATE_DBG
);

   localparam int BW = $clog2(BLANK_CYCLES + 1);
   localparam int FW = $clog2(FRAMES_PER_STEP + 1);
   localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
   localparam logic [BW-1:0] LAST_BLANK = BW'(BLANK_CYCLES - 1);
   localparam logic [FW-1:0] FPS_C      = FW'(FRAMES_PER_STEP);

   scan_state_t   state_q;
   logic [RW-1:0] row_idx_q;
   logic [BW-1:0] blank_cnt_q;
   logic [FW-1:0] frame_cnt_q;
   logic [ROWS-1:0] row_sel_q;
   logic          blank_q;
   logic          frame_start_q;
   logic          scroll_step_q;

   logic          ps_load;
   logic          ps_clr;
   logic          ps_run;
   logic          ps_tc;

   logic          last_blank;
   logic          row_wrap;
   logic [RW-1:0] row_idx_d;
   logic [FW-1:0] frame_cnt_d;
   logic          scroll_d;

   assign last_blank  = (blank_cnt_q == LAST_BLANK);
   assign row_wrap    = (row_idx_q == LAST_ROW);
   assign row_idx_d   = row_wrap ? '0 : row_idx_q + 1'b1;
   assign frame_cnt_d = frame_cnt_q + 1'b1;
   assign scroll_d    = (frame_cnt_d == FPS_C);

   // DIV is only sampled at frame boundaries, so a mid-frame change never
   // shortens or stretches the rows already in progress.
   always_comb begin
      ps_load = 1'b0;
      ps_clr  = 1'b0;
      ps_run  = 1'b0;
      if (!EN) begin
         ps_clr = 1'b1;
      end else begin
         case (state_q)
            S_IDLE:  ps_load = 1'b1;
            S_DRIVE: begin
               if (ps_tc) ps_clr = 1'b1;
               else       ps_run = 1'b1;
            end
            S_BLANK: ps_load = last_blank && row_wrap;
            default: ps_clr = 1'b1;
         endcase
      end
   end

   tick_prescaler #(
      .W (DIV_WIDTH)
   ) u_prescaler (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (ps_load),
      .load_val_i (DIV),
      .clr_i      (ps_clr),
      .run_i      (ps_run),
      .tc_o       (ps_tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= S_IDLE;
         row_idx_q     <= '0;
         blank_cnt_q   <= '0;
         frame_cnt_q   <= '0;
         row_sel_q     <= '0;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
         scroll_step_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         scroll_step_q <= 1'b0;
         if (!EN) begin
            state_q     <= S_IDLE;
            row_idx_q   <= '0;
            blank_cnt_q <= '0;
            frame_cnt_q <= '0;
            row_sel_q   <= '0;
            blank_q     <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q       <= S_DRIVE;
                  row_idx_q     <= '0;
                  row_sel_q     <= ROWS'(1);
                  frame_cnt_q   <= '0;
                  frame_start_q <= 1'b1;
               end
               S_DRIVE: begin
                  if (ps_tc) begin
                     state_q     <= S_BLANK;
                     row_sel_q   <= '0;
                     blank_q     <= 1'b1;
                     blank_cnt_q <= '0;
                  end
               end
               S_BLANK: begin
                  if (last_blank) begin
                     state_q     <= S_DRIVE;
                     blank_q     <= 1'b0;
                     blank_cnt_q <= '0;
                     row_idx_q   <= row_idx_d;
                     row_sel_q   <= ROWS'(1) << row_idx_d;
                     if (row_wrap) begin
                        frame_start_q <= 1'b1;
                        if (scroll_d) begin
                           frame_cnt_q   <= '0;
                           scroll_step_q <= 1'b1;
                        end else begin
                           frame_cnt_q <= frame_cnt_d;
                        end
                     end
                  end else begin
                     blank_cnt_q <= blank_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q   <= S_IDLE;
                  row_sel_q <= '0;
                  blank_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ROW_SEL     = row_sel_q;
   assign ROW_IDX     = row_idx_q;
   assign BLANK       = blank_q;
   assign FRAME_START = frame_start_q;
   assign SCROLL_STEP = scroll_step_q;
   assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_panel_scan_scheduler.sv
// Bench for panel_scan_scheduler with ROWS=7, BLANK_CYCLES=2,
// FRAMES_PER_STEP=3 and a nominal divide of 4.
module tb_panel_scan_scheduler;
   import panel_pkg::*;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          clk_run = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic [DW-1:0] div = 16'd4;
   logic [6:0]    row_sel;
   logic [2:0]    row_idx;
   logic          blank;
   logic          frame_start;
   logic          scroll_step;
   scan_state_t   state_dbg;

   int n_total = 0;
   int n_pass  = 0;

   panel_scan_scheduler #(
      .DIV_WIDTH       (DW),
      .ROWS            (7),
      .BLANK_CYCLES    (2),
      .FRAMES_PER_STEP (3)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .EN          (en),
      .DIV         (div),
      .ROW_SEL     (row_sel),
      .ROW_IDX     (row_idx),
      .BLANK       (blank),
      .FRAME_START (frame_start),
      .SCROLL_STEP (scroll_step),
      .STATE_DBG   (state_dbg)
   );

   // clock / reset block: clock can be held still to exercise async reset
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   typedef struct {
      logic       en;
      logic [6:0] rs;
      logic       bl;
      logic [2:0] idx;
      logic       fs;
      logic       ss;
      logic [1:0] st;
   } vec_t;

   vec_t tv[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic add(input logic e, input logic [6:0] rs, input logic bl, input logic [2:0] idx,
                      input logic fs, input logic ss, input scan_state_t st, input int reps);
      vec_t v;
      v.en = e; v.rs = rs; v.bl = bl; v.idx = idx; v.fs = fs; v.ss = ss; v.st = st;
      for (int i = 0; i < reps; i++) tv.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_rowsel"}, 32'(row_sel), 32'd0);
      check({name, "_blank"}, 32'(blank), 32'd0);
      check({name, "_fs"}, 32'(frame_start), 32'd0);
      check({name, "_ss"}, 32'(scroll_step), 32'd0);
      check({name, "_idx"}, 32'(row_idx), 32'd0);
      check({name, "_state"}, 32'(state_dbg), 32'(S_IDLE));
   endtask

   initial begin
      int r2;
      int phase;
      int nfr;
      int row;
      logic drv;
      logic exp_fs;
      logic exp_ss;

      // reset with the clock stopped, EN already high
      en = 1'b1;
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      clk_run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("rst_hold_en");
      rst = 1'b0;
      en  = 1'b0;

      // basic scan of rows 0..2, then stop in row 2's third cycle and restart
      add(1, 7'b0000001, 0, 0, 1, 0, S_DRIVE, 1);
      add(1, 7'b0000001, 0, 0, 0, 0, S_DRIVE, 4);
      add(1, 7'b0000000, 1, 0, 0, 0, S_BLANK, 2);
      add(1, 7'b0000010, 0, 1, 0, 0, S_DRIVE, 5);
      add(1, 7'b0000000, 1, 1, 0, 0, S_BLANK, 2);
      add(1, 7'b0000100, 0, 2, 0, 0, S_DRIVE, 3);
      add(0, 7'b0000000, 0, 0, 0, 0, S_IDLE,  2);
      add(1, 7'b0000001, 0, 0, 1, 0, S_DRIVE, 1);

      for (int i = 0; i < tv.size(); i++) begin
         en = tv[i].en;
         step();
         check($sformatf("vec%0d_rowsel", i), 32'(row_sel), 32'(tv[i].rs));
         check($sformatf("vec%0d_blank", i), 32'(blank), 32'(tv[i].bl));
         check($sformatf("vec%0d_idx", i), 32'(row_idx), 32'(tv[i].idx));
         check($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(tv[i].fs));
         check($sformatf("vec%0d_ss", i), 32'(scroll_step), 32'(tv[i].ss));
         check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(tv[i].st));
      end

      // continuous run from the restart: periods 49 / 147, then DIV 4->0 in
      // row 3 of the frame at 294, taking effect at the frame starting at 343
      for (int rel = 1; rel <= 411; rel++) begin
         if (rel == 317) div = 16'd0;
         step();
         if (rel < 343) begin
            phase  = rel % 49;
            nfr    = rel / 49;
            row    = phase / 7;
            drv    = (phase % 7) < 5;
            exp_fs = (phase == 0);
         end else begin
            r2     = rel - 343;
            phase  = r2 % 21;
            nfr    = 7 + r2 / 21;
            row    = phase / 3;
            drv    = (phase % 3) == 0;
            exp_fs = (phase == 0);
         end
         exp_ss = exp_fs && (nfr % 3 == 0);
         check($sformatf("run%0d_rowsel", rel), 32'(row_sel), drv ? (32'd1 << row) : 32'd0);
         check($sformatf("run%0d_blank", rel), 32'(blank), 32'(!drv));
         check($sformatf("run%0d_fs", rel), 32'(frame_start), 32'(exp_fs));
         check($sformatf("run%0d_ss", rel), 32'(scroll_step), 32'(exp_ss));
         check($sformatf("run%0d_excl", rel), 32'((|row_sel) & blank), 32'd0);
      end

      // stop, restart with DIV=4 and hit async reset during row 5
      en = 1'b0;
      step();
      check_all_zero("stop2");
      div = 16'd4;
      en  = 1'b1;
      step();
      check("rs_restart_fs", 32'(frame_start), 32'd1);
      check("rs_restart_row", 32'(row_sel), 32'd1);
      repeat (36) step();
      check("row5_rowsel", 32'(row_sel), 32'b0100000);
      check("row5_idx", 32'(row_idx), 32'd5);
      #2 rst = 1'b1;
      #1 check_all_zero("mid_rst");
      #1 rst = 1'b0;
      step();
      check("post_rst_row", 32'(row_sel), 32'd1);
      check("post_rst_fs", 32'(frame_start), 32'd1);
      check("post_rst_idx", 32'(row_idx), 32'd0);
      check("post_rst_state", 32'(state_dbg), 32'(S_DRIVE));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
